// File: rtl/hub75_row_scanner_pkg.sv
// hub75_pkg: shared state encoding and width helpers for the HUB75 row scanner.
`default_nettype none

package hub75_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    BLANK = 2'd2,
    LATCH = 2'd3
  } state_e;

  localparam int PIXELS_PER_ROW_DEF = 64;
  localparam int COL_W = $clog2(PIXELS_PER_ROW_DEF);

  // Counter width that stays at least one bit for terminal counts of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hub75_row_scanner_edge.sv
// rising_edge_detect: one-cycle pulse on each rising edge of the divided clock.
`default_nettype none

module rising_edge_detect (
  input  logic clk_in,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic tick_q;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) tick_q <= 1'b0;
    else        tick_q <= sig_i;
  end

  assign rise_o = sig_i & ~tick_q;

endmodule

`default_nettype wire

// File: rtl/hub75_row_scanner.sv
// hub75_row_scanner: sequences column shift, blanking, latch and row advance
// for one HUB75 panel row per pass, paced by the divided pixel-rate tick.
`default_nettype none

module hub75_row_scanner
  import hub75_pkg::*;
#(
  parameter int PIXELS_PER_ROW = 64,
  parameter int ROW_ADDR_WIDTH = 5,
  parameter int BLANK_TICKS    = 4
) (
  input  logic                              clk_in,
  input  logic                              reset,
  input  logic                              tick_src,
  input  logic                              enable,
  output logic [$clog2(PIXELS_PER_ROW)-1:0] pixel_col,
  output logic [ROW_ADDR_WIDTH-1:0]         row_addr,
  output logic                              pixel_clk,
  output logic                              latch,
  output logic                              oe_n,
  output logic                              row_done
);

  localparam int CW = $clog2(PIXELS_PER_ROW);
  localparam int BW = cnt_width(BLANK_TICKS);
  localparam logic [CW-1:0] COL_LAST   = CW'(PIXELS_PER_ROW - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_TICKS - 1);

  logic tick;

  rising_edge_detect u_edge (
    .clk_in (clk_in),
    .reset  (reset),
    .sig_i  (tick_src),
    .rise_o (tick)
  );

  state_e                    state_q, state_d;
  logic [CW-1:0]             col_q, col_d;
  logic [ROW_ADDR_WIDTH-1:0] row_q, row_d;
  logic [BW-1:0]             blank_q, blank_d;
  logic                      pclk_q, pclk_d;
  logic                      latch_q, latch_d;
  logic                      oe_n_q, oe_n_d;
  logic                      shown_q, shown_d;
  logic                      done_q, done_d;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      blank_q <= '0;
      pclk_q  <= 1'b0;
      latch_q <= 1'b0;
      oe_n_q  <= 1'b1;
      shown_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      blank_q <= blank_d;
      pclk_q  <= pclk_d;
      latch_q <= latch_d;
      oe_n_q  <= oe_n_d;
      shown_q <= shown_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    blank_d = blank_q;
    pclk_d  = pclk_q;
    latch_d = latch_q;
    oe_n_d  = oe_n_q;
    shown_d = shown_q;
    done_d  = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          oe_n_d = 1'b1;
          pclk_d = 1'b0;
          if (enable) begin
            state_d = SHIFT;
            col_d   = '0;
          end
        end
        SHIFT: begin
          pclk_d = ~pclk_q;
          // The falling edge after the last column's rise ends the shift phase.
          if (pclk_q) begin
            if (col_q == COL_LAST) begin
              state_d = BLANK;
              oe_n_d  = 1'b1;
              blank_d = '0;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        BLANK: begin
          if (blank_q == BLANK_LAST) begin
            state_d = LATCH;
            latch_d = 1'b1;
            blank_d = '0;
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end
        LATCH: begin
          latch_d = 1'b0;
          row_d   = row_q + 1'b1;
          done_d  = 1'b1;
          col_d   = '0;
          if (enable) begin
            state_d = SHIFT;
            oe_n_d  = 1'b0;
            shown_d = 1'b1;
          end else begin
            state_d = IDLE;
            oe_n_d  = 1'b1;
            shown_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pixel_col = col_q;
  assign row_addr  = row_q;
  assign pixel_clk = pclk_q;
  assign latch     = latch_q;
  assign oe_n      = oe_n_q;
  assign row_done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_hub75_row_scanner.sv
// Directed bench for hub75_row_scanner: 4 columns, 4 rows, 2 blank ticks,
// tick source toggling every 5 clk_in cycles (one tick per 10 cycles).
`default_nettype none

module tb_hub75_row_scanner;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic       enable = 1'b0;
  logic       div_q  = 1'b0;
  logic [2:0] div_cnt = 3'd0;
  logic       force_on  = 1'b0;
  logic       force_val = 1'b0;
  logic       tick_src;
  logic [1:0] pixel_col;
  logic [1:0] row_addr;
  logic       pixel_clk, latch, oe_n, row_done;

  assign tick_src = force_on ? force_val : div_q;

  hub75_row_scanner #(
    .PIXELS_PER_ROW (4),
    .ROW_ADDR_WIDTH (2),
    .BLANK_TICKS    (2)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .tick_src  (tick_src),
    .enable    (enable),
    .pixel_col (pixel_col),
    .row_addr  (row_addr),
    .pixel_clk (pixel_clk),
    .latch     (latch),
    .oe_n      (oe_n),
    .row_done  (row_done)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (div_cnt == 3'd4) begin
      div_cnt <= 3'd0;
      div_q   <= ~div_q;
    end else begin
      div_cnt <= div_cnt + 3'd1;
    end
  end

  int nchk = 0;
  int nerr = 0;
  int cyc = 0, done_cnt = 0, rise_cnt = 0, toggle_cnt = 0, viol = 0;
  int last_done_cyc = 0, latch_start = 0, oe_rise_cyc = 0;
  int rise_cols[$];
  int periods[$];
  int latch_w[$];
  int oe_hi[$];
  logic prev_pclk = 1'b0, prev_latch = 1'b0, prev_oe = 1'b1, prev_done = 1'b0;
  logic [1:0] prev_row = 2'd0;

  // Event monitor sampled on the falling edge, away from state updates.
  always @(negedge clk_in) begin
    cyc <= cyc + 1;
    if (!reset) begin
      prev_pclk  <= 1'b0;
      prev_latch <= 1'b0;
      prev_oe    <= 1'b1;
      prev_done  <= 1'b0;
      prev_row   <= 2'd0;
    end else begin
      if (pixel_clk != prev_pclk) toggle_cnt <= toggle_cnt + 1;
      if (pixel_clk && !prev_pclk) begin
        rise_cnt <= rise_cnt + 1;
        rise_cols.push_back(int'(pixel_col));
      end
      if (row_done) begin
        if (done_cnt > 0) periods.push_back(cyc - last_done_cyc);
        done_cnt      <= done_cnt + 1;
        last_done_cyc <= cyc;
      end
      if (oe_n && !prev_oe) oe_rise_cyc <= cyc;
      if (latch && !prev_latch) begin
        latch_start <= cyc;
        oe_hi.push_back(cyc - oe_rise_cyc);
      end
      if (!latch && prev_latch) latch_w.push_back(cyc - latch_start);
      if (latch && !oe_n) viol <= viol + 1;
      if (pixel_clk && latch) viol <= viol + 1;
      if (row_done && prev_done) viol <= viol + 1;
      if (row_addr != prev_row && !row_done && !oe_n) viol <= viol + 1;
      prev_pclk  <= pixel_clk;
      prev_latch <= latch;
      prev_oe    <= oe_n;
      prev_done  <= row_done;
      prev_row   <= row_addr;
    end
  end

  task automatic chk(input string tag, input int got, input int exp_v);
    nchk++;
    if (got !== exp_v) begin
      nerr++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic wait_done(input string tag);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, int'(done_cnt != start), 1);
  endtask

  task automatic wait_rise(input string tag);
    int start;
    int n;
    start = rise_cnt;
    n = 0;
    while (rise_cnt == start && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, int'(rise_cnt != start), 1);
  endtask

  int exp_rows[4] = '{1, 2, 3, 0};
  int snap_rise, snap_done, snap_tog;

  initial begin
    repeat (5) step();
    chk("rst_oe_n", int'(oe_n), 1);
    chk("rst_pclk", int'(pixel_clk), 0);
    chk("rst_latch", int'(latch), 0);
    chk("rst_row", int'(row_addr), 0);
    chk("rst_col", int'(pixel_col), 0);
    chk("rst_done", int'(row_done), 0);

    reset  = 1'b1;
    enable = 1'b1;

    // Four full rows from reset.
    for (int i = 0; i < 4; i++) begin
      wait_done($sformatf("row%0d", i));
      chk($sformatf("row%0d_addr", i), int'(row_addr), exp_rows[i]);
      chk($sformatf("row%0d_oe_n", i), int'(oe_n), 0);
      chk($sformatf("row%0d_col", i), int'(pixel_col), 0);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("rise_col%0d", i), rise_cols.size() > i ? rise_cols[i] : -1, i);
    chk("rises_4rows", rise_cnt, 16);
    for (int i = 0; i < 3; i++)
      chk($sformatf("period%0d", i), periods.size() > i ? periods[i] : -1, 110);
    chk("latch_width", latch_w.size() > 0 ? latch_w[0] : -1, 10);
    chk("blank_before_latch", oe_hi.size() > 1 ? oe_hi[1] : -1, 20);

    // Drop enable while row 2 is shifting.
    wait_done("to_row1");
    wait_done("to_row2");
    chk("row2_addr", int'(row_addr), 2);
    for (int i = 0; i < 3; i++) wait_rise($sformatf("r2_rise%0d", i));
    enable = 1'b0;
    wait_done("stop_row");
    chk("stop_addr", int'(row_addr), 3);
    chk("stop_oe_n", int'(oe_n), 1);
    chk("stop_col", int'(pixel_col), 0);
    snap_rise = rise_cnt;
    snap_done = done_cnt;
    repeat (300) step();
    chk("idle_rises", rise_cnt - snap_rise, 0);
    chk("idle_dones", done_cnt - snap_done, 0);
    chk("idle_pclk", int'(pixel_clk), 0);
    chk("idle_oe_n", int'(oe_n), 1);
    chk("idle_row", int'(row_addr), 3);

    enable = 1'b1;
    wait_rise("resume");
    chk("resume_row", int'(row_addr), 3);
    chk("resume_oe_n", int'(oe_n), 1);
    chk("resume_col", int'(pixel_col), 0);

    // Held-high tick source must produce a single tick.
    force_val = 1'b0;
    force_on  = 1'b1;
    repeat (3) step();
    snap_tog  = toggle_cnt;
    force_val = 1'b1;
    repeat (20) step();
    chk("held_toggles", toggle_cnt - snap_tog, 1);
    chk("held_pclk", int'(pixel_clk), 0);
    chk("held_col", int'(pixel_col), 1);
    force_on = 1'b0;

    wait_done("after_held");
    chk("after_held_row", int'(row_addr), 0);
    chk("after_held_oe_n", int'(oe_n), 0);

    // Asynchronous reset in the middle of a shift.
    wait_done("pre_rst");
    chk("pre_rst_row", int'(row_addr), 1);
    wait_rise("pre_rst_rise");
    #1;
    reset = 1'b0;
    #1;
    chk("async_oe_n", int'(oe_n), 1);
    chk("async_pclk", int'(pixel_clk), 0);
    chk("async_latch", int'(latch), 0);
    chk("async_row", int'(row_addr), 0);
    chk("async_col", int'(pixel_col), 0);
    repeat (3) step();
    reset = 1'b1;
    repeat (3) step();

    chk("protocol_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

`default_nettype wire
